// File: rtl/dma_req_pkg.sv
// Shared types and helpers for the peripheral-side DMA requester.
package dma_req_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } req_state_e;

    // Returns {fall, rise} for an active-low strobe, given last and current samples.
    function automatic logic [1:0] strobe_edge(input logic prev_n, input logic cur_n);
        return {prev_n & ~cur_n, ~prev_n & cur_n};
    endfunction

endpackage

// File: rtl/dma_req_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
module dma_req_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              wr_ok_s;
    logic              rd_ok_s;

    assign full    = (level_r == LVL_W'(DEPTH));
    assign empty   = (level_r == LVL_W'(0));
    assign level   = level_r;
    assign head    = mem_r[rd_ptr_r];
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks net writes minus reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/dma_io_requester.sv
// Peripheral-side DMA requester: raises DREQ, answers DACK with IOR_N/IOW_N
// strobes against a local FIFO, and terminates blocks on EOP_N.
module dma_io_requester
    import dma_req_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int THRESH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_IN,
    output logic [DATA_W-1:0] DB_OUT,
    output logic              DB_OE,
    input  logic              enable,
    input  logic              dir,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic [LVL_W-1:0]  level,
    output logic              tc_pulse,
    output logic              overrun,
    output logic              underrun
);

    req_state_e        state_r;
    logic              dir_q_r;
    logic              eop_seen_r;
    logic              dreq_r;
    logic              tc_pulse_r;
    logic              ior_prev_r;
    logic              iow_prev_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              db_oe_r;
    logic [DATA_W-1:0] db_out_r;
    logic              overrun_r;
    logic              underrun_r;

    logic              full_s;
    logic              empty_s;
    logic [LVL_W-1:0]  level_s;
    logic [LVL_W-1:0]  level_next_s;
    logic [DATA_W-1:0] head_s;
    logic [1:0]        ior_edge_s;
    logic [1:0]        iow_edge_s;
    logic              xfer_ok_s;
    logic              rd_fall_s;
    logic              rd_rise_s;
    logic              wr_rise_s;
    logic              dma_pop_s;
    logic              dma_push_s;
    logic              loc_push_s;
    logic              loc_pop_s;
    logic              fifo_wr_s;
    logic              fifo_rd_s;
    logic [DATA_W-1:0] fifo_wdata_s;
    logic              cond_s;
    logic              eop_now_s;
    logic              strobe_open_s;
    logic              drop_s;

    assign push_ready = !full_s && !dir_q_r;
    assign pop_valid  = !empty_s && dir_q_r;
    assign pop_data   = head_s;
    assign level      = level_s;
    assign DREQ       = dreq_r;
    assign DB_OE      = db_oe_r;
    assign DB_OUT     = db_out_r;
    assign tc_pulse   = tc_pulse_r;
    assign overrun    = overrun_r;
    assign underrun   = underrun_r;

    // Controller strobes only count while this channel is acknowledged mid-transfer.
    assign ior_edge_s = strobe_edge(ior_prev_r, IOR_N);
    assign iow_edge_s = strobe_edge(iow_prev_r, IOW_N);
    assign xfer_ok_s  = (state_r == XFER) && DACK;
    assign rd_fall_s  = xfer_ok_s && !dir_q_r && ior_edge_s[1];
    assign rd_rise_s  = xfer_ok_s && !dir_q_r && ior_edge_s[0];
    assign wr_rise_s  = xfer_ok_s && dir_q_r && iow_edge_s[0];

    assign dma_pop_s    = rd_rise_s && !empty_s;
    assign dma_push_s   = wr_rise_s && !full_s;
    assign loc_push_s   = push_valid && push_ready;
    assign loc_pop_s    = pop_ready && pop_valid;
    assign fifo_wr_s    = loc_push_s || dma_push_s;
    assign fifo_rd_s    = loc_pop_s || dma_pop_s;
    assign fifo_wdata_s = dir_q_r ? wr_data_r : push_data;

    assign cond_s = dir_q_r ? ((LVL_W'(DEPTH) - level_s) >= LVL_W'(THRESH))
                            : ((level_s >= LVL_W'(THRESH)) || (flush && (level_s != LVL_W'(0))));
    assign eop_now_s     = xfer_ok_s && !EOP_N;
    assign strobe_open_s = dir_q_r ? !IOW_N : !IOR_N;
    assign drop_s        = !enable || eop_now_s
                         || (dma_pop_s && (level_next_s == LVL_W'(0)))
                         || (dma_push_s && (level_next_s == LVL_W'(DEPTH)));

    // Occupancy after this edge, used to drop DREQ as a transfer empties or fills the FIFO.
    always_comb begin
        level_next_s = level_s;
        case ({fifo_wr_s, fifo_rd_s})
            2'b10:   level_next_s = level_s + LVL_W'(1);
            2'b01:   level_next_s = level_s - LVL_W'(1);
            default: level_next_s = level_s;
        endcase
    end

    dma_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (CLK),
        .reset   (RESET),
        .wr_en   (fifo_wr_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (fifo_rd_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_s),
        .head    (head_s)
    );

    // Request FSM with registered DREQ and tc_pulse; dir is sampled only while idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= IDLE;
            dir_q_r    <= 1'b0;
            eop_seen_r <= 1'b0;
            dreq_r     <= 1'b0;
            tc_pulse_r <= 1'b0;
        end else begin
            tc_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    dir_q_r    <= dir;
                    eop_seen_r <= 1'b0;
                    dreq_r     <= 1'b0;
                    if (enable && cond_s) begin
                        state_r <= REQ;
                        dreq_r  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!enable || !cond_s) begin
                        state_r <= IDLE;
                        dreq_r  <= 1'b0;
                    end else if (DACK) begin
                        state_r <= XFER;
                    end
                end
                XFER: begin
                    if (eop_now_s) begin
                        eop_seen_r <= 1'b1;
                    end
                    // EOP waits for any open strobe so the last byte completes.
                    if ((eop_seen_r || eop_now_s) && !strobe_open_s) begin
                        state_r    <= DONE;
                        dreq_r     <= 1'b0;
                        tc_pulse_r <= 1'b1;
                    end else if (!DACK && !strobe_open_s) begin
                        state_r <= IDLE;
                        dreq_r  <= 1'b0;
                    end else if (drop_s) begin
                        dreq_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    dreq_r  <= 1'b0;
                end
            endcase
        end
    end

    // Strobe history, write-data capture, data bus drive and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ior_prev_r <= 1'b1;
            iow_prev_r <= 1'b1;
            wr_data_r  <= DATA_W'(0);
            db_oe_r    <= 1'b0;
            db_out_r   <= DATA_W'(0);
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            ior_prev_r <= IOR_N;
            iow_prev_r <= IOW_N;
            if (!IOW_N) begin
                wr_data_r <= DB_IN;
            end
            if (!DACK) begin
                db_oe_r <= 1'b0;
            end else if (rd_fall_s) begin
                db_oe_r  <= 1'b1;
                db_out_r <= empty_s ? DATA_W'(0) : head_s;
            end else if (rd_rise_s) begin
                db_oe_r <= 1'b0;
            end
            if (rd_rise_s && empty_s) begin
                underrun_r <= 1'b1;
            end
            if (wr_rise_s && full_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_io_requester.sv
// Directed bench for dma_io_requester: queue-based FIFO model checked every cycle plus literal checkpoints.
module tb_dma_io_requester;

    logic       CLK = 1'b0;
    logic       RESET, DREQ, DACK, IOR_N, IOW_N, EOP_N, DB_OE;
    logic [7:0] DB_IN, DB_OUT, push_data, pop_data;
    logic       enable, dir, flush, push_valid, push_ready, pop_ready, pop_valid;
    logic [4:0] level;
    logic       tc_pulse, overrun, underrun;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         chk_en = 1'b0;

    logic [7:0] fifo_q[$];
    bit         ovr_m, und_m, oe_m, dirq_m;
    logic [7:0] dbout_m;

    always #5 CLK = ~CLK;

    dma_io_requester dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .enable(enable),
        .dir(dir), .flush(flush), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .pop_ready(pop_ready), .pop_valid(pop_valid),
        .pop_data(pop_data), .level(level), .tc_pulse(tc_pulse), .overrun(overrun),
        .underrun(underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the queue model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_level", 32'(level), 32'(fifo_q.size()));
            chk("m_push_ready", 32'(push_ready), 32'(fifo_q.size() < 16 && !dirq_m));
            chk("m_pop_valid", 32'(pop_valid), 32'(fifo_q.size() > 0 && dirq_m));
            if (fifo_q.size() > 0 && dirq_m) chk("m_pop_data", 32'(pop_data), 32'(fifo_q[0]));
            chk("m_overrun", 32'(overrun), 32'(ovr_m));
            chk("m_underrun", 32'(underrun), 32'(und_m));
            chk("m_db_oe", 32'(DB_OE), 32'(oe_m));
            if (oe_m) chk("m_db_out", 32'(DB_OUT), 32'(dbout_m));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        fifo_q.delete();
        ovr_m = 1'b0; und_m = 1'b0; oe_m = 1'b0; dirq_m = 1'b0;
        chk_en = 1'b1;
        RESET = 1'b0;
        tick();
        dirq_m = dir;
    endtask

    task automatic set_dir(input logic d);
        dir = d;
        tick();
        dirq_m = d;
    endtask

    task automatic local_push(input logic [7:0] d);
        push_valid = 1'b1; push_data = d;
        tick();
        push_valid = 1'b0;
        fifo_q.push_back(d);
    endtask

    task automatic local_pop(input logic [7:0] exp);
        chk("local_pop_data", 32'(pop_data), 32'(exp));
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        void'(fifo_q.pop_front());
    endtask

    task automatic dma_read(input logic [7:0] exp);
        IOR_N = 1'b0;
        tick();
        oe_m = 1'b1;
        dbout_m = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
        chk("dma_read_data", 32'(DB_OUT), 32'(exp));
        IOR_N = 1'b1;
        tick();
        oe_m = 1'b0;
        if (fifo_q.size() == 0) und_m = 1'b1;
        else void'(fifo_q.pop_front());
    endtask

    task automatic dma_write(input logic [7:0] d);
        DB_IN = d; IOW_N = 1'b0;
        tick();
        IOW_N = 1'b1;
        tick();
        if (fifo_q.size() >= 16) ovr_m = 1'b1;
        else fifo_q.push_back(d);
    endtask

    initial begin
        RESET = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1; DB_IN = 8'h00;
        enable = 1'b0; dir = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = 8'h00;
        pop_ready = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        chk("rst_dreq", 32'(DREQ), 32'd0);
        chk("rst_db_oe", 32'(DB_OE), 32'd0);
        chk("rst_db_out", 32'(DB_OUT), 32'd0);
        chk("rst_tc", 32'(tc_pulse), 32'd0);
        chk("rst_flags", 32'({overrun, underrun}), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        do_reset();

        // dir 0: four pushes reach THRESH, controller reads them back in order
        enable = 1'b1;
        for (int i = 0; i < 4; i++) local_push(8'hA0 + 8'(i));
        chk("t1_dreq_not_yet", 32'(DREQ), 32'd0);
        tick();
        chk("t1_dreq_up", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick();
        dma_read(8'hA0); dma_read(8'hA1); dma_read(8'hA2);
        chk("t1_dreq_mid", 32'(DREQ), 32'd1);
        dma_read(8'hA3);
        chk("t1_dreq_empty", 32'(DREQ), 32'd0);
        DACK = 1'b0; enable = 1'b0;
        tick();

        // dir 1: three controller writes then EOP
        set_dir(1'b1);
        enable = 1'b1;
        tick();
        chk("t2_dreq_up", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick();
        dma_write(8'h11); dma_write(8'h22); dma_write(8'h33);
        EOP_N = 1'b0; enable = 1'b0;
        tick();
        chk("t2_tc_high", 32'(tc_pulse), 32'd1);
        chk("t2_dreq_eop", 32'(DREQ), 32'd0);
        EOP_N = 1'b1; DACK = 1'b0;
        tick();
        chk("t2_tc_once", 32'(tc_pulse), 32'd0);
        local_pop(8'h11); local_pop(8'h22); local_pop(8'h33);

        // dir 0 flush with two entries, third read underruns
        set_dir(1'b0);
        local_push(8'hB0); local_push(8'hB1);
        flush = 1'b1; enable = 1'b1;
        tick();
        chk("t3_dreq_flush", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick();
        dma_read(8'hB0); dma_read(8'hB1);
        chk("t3_dreq_empty", 32'(DREQ), 32'd0);
        dma_read(8'h00);
        chk("t3_underrun", 32'(underrun), 32'd1);
        chk("t3_level", 32'(level), 32'd0);
        DACK = 1'b0; flush = 1'b0; enable = 1'b0;
        tick();

        // dir 1: fill all 16 entries, one more write overruns and is dropped
        set_dir(1'b1);
        enable = 1'b1;
        tick();
        DACK = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) dma_write(8'h40 + 8'(i));
        chk("t4_dreq_full", 32'(DREQ), 32'd0);
        chk("t4_level_full", 32'(level), 32'd16);
        dma_write(8'hFF);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_level_kept", 32'(level), 32'd16);
        DACK = 1'b0; enable = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) local_pop(8'h40 + 8'(i));
        chk("t4_drained", 32'(pop_valid), 32'd0);

        // dir 0: local push coincides with IOR_N rise at level 5
        set_dir(1'b0);
        for (int i = 0; i < 5; i++) local_push(8'hC0 + 8'(i));
        enable = 1'b1;
        tick();
        chk("t5_dreq_up", 32'(DREQ), 32'd1);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        tick();
        oe_m = 1'b1; dbout_m = fifo_q[0];
        chk("t5_read_data", 32'(DB_OUT), 32'hC0);
        IOR_N = 1'b1; push_valid = 1'b1; push_data = 8'hC5;
        tick();
        push_valid = 1'b0;
        oe_m = 1'b0;
        void'(fifo_q.pop_front());
        fifo_q.push_back(8'hC5);
        chk("t5_level_same", 32'(level), 32'd5);
        DACK = 1'b0; enable = 1'b0;
        tick();
        set_dir(1'b1);
        for (int i = 1; i < 6; i++) local_pop(8'hC0 + 8'(i));

        // RESET while IOR_N strobe is open
        set_dir(1'b0);
        for (int i = 0; i < 4; i++) local_push(8'hD0 + 8'(i));
        enable = 1'b1;
        tick();
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        tick();
        oe_m = 1'b1; dbout_m = fifo_q[0];
        chk("t6_oe_open", 32'(DB_OE), 32'd1);
        RESET = 1'b1;
        tick();
        fifo_q.delete();
        ovr_m = 1'b0; und_m = 1'b0; oe_m = 1'b0; dirq_m = 1'b0;
        chk("t6_oe_reset", 32'(DB_OE), 32'd0);
        chk("t6_dreq_reset", 32'(DREQ), 32'd0);
        chk("t6_level_reset", 32'(level), 32'd0);
        RESET = 1'b0; IOR_N = 1'b1; DACK = 1'b0; enable = 1'b0;
        tick();
        dirq_m = dir;
        tick();
        chk("t6_idle", 32'(DREQ), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
